// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: moves the ball once per frame and reports position, lost balls and lives.
//
// Ports
//   pclk          pixel clock, the only clock
//   rst_n         asynchronous active-low reset
//   frame_tick    one-pclk pulse per frame
//   start         one-pclk launch request
//   paddle_x      left edge of the paddle
//   collision_det block collision flag from the collision detector
//   x_pos, y_pos  registered ball top-left corner
//   ball_lost     one-pclk pulse when the ball reaches the floor
//   lives_left    remaining balls
//   game_over     high once lives reach zero (cleared only by reset)
//
// Optional feature: define BALL_SPEEDUP_EN to speed the ball up by one pixel per frame after
// every 8 applied block bounces, saturating at twice STEP.

module ball_motion_ctrl #(
  parameter int unsigned SCREEN_W  = 800,
  parameter int unsigned SCREEN_H  = 600,
  parameter int unsigned BALL_SIZE = 10,
  parameter int unsigned STEP      = 2,
  parameter int unsigned PADDLE_Y  = 560,
  parameter int unsigned PADDLE_W  = 100,
  parameter int unsigned COOLDOWN  = 3,
  parameter int unsigned LIVES     = 3
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [11:0] paddle_x,
  input  logic        collision_det,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        ball_lost,
  output logic [1:0]  lives_left,
  output logic        game_over
);

  localparam int unsigned CdW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  // 13-bit constants keep the position arithmetic free of wrap-around.
  localparam logic [12:0] ScrW    = 13'(SCREEN_W);
  localparam logic [12:0] ScrH    = 13'(SCREEN_H);
  localparam logic [12:0] Bs      = 13'(BALL_SIZE);
  localparam logic [12:0] PadY    = 13'(PADDLE_Y);
  localparam logic [12:0] PadW    = 13'(PADDLE_W);
  localparam logic [12:0] StepC   = 13'(STEP);
  localparam logic [11:0] StartX  = 12'(SCREEN_W / 2 - BALL_SIZE / 2);
  localparam logic [11:0] IdleY   = 12'(PADDLE_Y - BALL_SIZE);
  localparam logic [11:0] RightX  = 12'(SCREEN_W - BALL_SIZE);
  localparam logic [11:0] CentOff = 12'(PADDLE_W / 2) - 12'(BALL_SIZE / 2);

  typedef enum logic [1:0] {StIdle, StMove, StLost, StOver} state_e;

  state_e           state_q, state_d;
  logic [11:0]      x_q, x_d, y_q, y_d;
  logic             dx_neg_q, dx_neg_d;   // 1: moving left
  logic             dy_down_q, dy_down_d; // 1: moving down
  logic             pending_q, pending_d;
  logic [CdW-1:0]   cd_q, cd_d;
  logic [1:0]       lives_q, lives_d;
  logic             lost_q, lost_d;
  logic             over_q, over_d;

  logic [12:0]      step;
  logic             cd_zero;
  logic             bounce;

  assign cd_zero = (cd_q == '0);
  // A collision seen in the tick cycle itself still counts for this frame.
  assign bounce  = pending_q | (collision_det & cd_zero);

`ifdef BALL_SPEEDUP_EN
  localparam logic [12:0] StepMax = 13'(2 * STEP);

  logic [2:0]  hits_q, hits_d;
  logic [12:0] step_q, step_d;

  always_comb begin
    hits_d = hits_q;
    step_d = step_q;
    if (state_q != StIdle && state_d == StIdle) begin
      hits_d = '0;
      step_d = StepC;
    end else if (state_q == StMove && frame_tick && bounce) begin
      hits_d = hits_q + 3'd1;
      if (hits_q == 3'd7 && step_q < StepMax) begin
        step_d = step_q + 13'd1;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q <= '0;
      step_q <= StepC;
    end else begin
      hits_q <= hits_d;
      step_q <= step_d;
    end
  end

  assign step = step_q;
`else
  assign step = StepC;
`endif

  logic [12:0] x13, y13, px13;
  logic [11:0] nx, ny;
  logic        ndx, ndy, hit_floor;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dx_neg_d  = dx_neg_q;
    dy_down_d = dy_down_q;
    pending_d = pending_q;
    cd_d      = cd_q;
    lives_d   = lives_q;
    lost_d    = 1'b0;
    over_d    = over_q;
    x13       = {1'b0, x_q};
    y13       = {1'b0, y_q};
    px13      = {1'b0, paddle_x};
    nx        = x_q;
    ny        = y_q;
    ndx       = dx_neg_q;
    ndy       = dy_down_q;
    hit_floor = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StMove;
          dx_neg_d  = 1'b0;
          dy_down_d = 1'b0;
          pending_d = 1'b0;
          cd_d      = '0;
        end else if (frame_tick) begin
          x_d = paddle_x + CentOff;
          y_d = IdleY;
        end
      end

      StMove: begin
        if (collision_det && cd_zero) begin
          pending_d = 1'b1;
        end
        if (frame_tick) begin
          pending_d = 1'b0;
          if (bounce) begin
            ndy  = ~dy_down_q;
            cd_d = CdW'(COOLDOWN);
          end else if (!cd_zero) begin
            cd_d = cd_q - CdW'(1);
          end

          // Wall clamps are evaluated after the block flip so they take precedence.
          if (ndx) begin
            if (x13 < step) begin
              nx  = '0;
              ndx = 1'b0;
            end else begin
              nx = 12'(x13 - step);
            end
          end else if (x13 + step + Bs > ScrW - 13'd1) begin
            nx  = RightX;
            ndx = 1'b1;
          end else begin
            nx = 12'(x13 + step);
          end

          if (!ndy) begin
            if (y13 < step) begin
              ny  = '0;
              ndy = 1'b1;
            end else begin
              ny = 12'(y13 - step);
            end
          end else if ((y13 + Bs <= PadY) && (PadY < y13 + step + Bs) &&
                       (x13 + Bs - 13'd1 >= px13) && (x13 <= px13 + PadW)) begin
            ny  = IdleY;
            ndy = 1'b0;
          end else if (y13 + step + Bs >= ScrH) begin
            hit_floor = 1'b1;
          end else begin
            ny = 12'(y13 + step);
          end

          if (hit_floor) begin
            state_d = StLost;
          end else begin
            x_d       = nx;
            y_d       = ny;
            dx_neg_d  = ndx;
            dy_down_d = ndy;
          end
        end
      end

      StLost: begin
        lost_d  = 1'b1;
        lives_d = lives_q - 2'd1;
        if (lives_q == 2'd1) begin
          state_d = StOver;
          over_d  = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end

      StOver: begin
        over_d = 1'b1;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      x_q       <= StartX;
      y_q       <= IdleY;
      dx_neg_q  <= 1'b0;
      dy_down_q <= 1'b0;
      pending_q <= 1'b0;
      cd_q      <= '0;
      lives_q   <= 2'(LIVES);
      lost_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dx_neg_q  <= dx_neg_d;
      dy_down_q <= dy_down_d;
      pending_q <= pending_d;
      cd_q      <= cd_d;
      lives_q   <= lives_d;
      lost_q    <= lost_d;
      over_q    <= over_d;
    end
  end

  assign x_pos      = x_q;
  assign y_pos      = y_q;
  assign ball_lost  = lost_q;
  assign lives_left = lives_q;
  assign game_over  = over_q;

endmodule
